// File: rtl/commit_pkg.sv
// Shared definitions for the commit-side recovery logic: sequencer state
// encodings and the default geometry / exception vector used by the
// recovery sequencer and its RAT copy walker.
package commit_pkg;

   // Recovery sequencer states, walked strictly in this order
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FLUSH    = 3'd1,
      DRAIN    = 3'd2,
      COPY     = 3'd3,
      REDIRECT = 3'd4
   } recState_t;

   localparam int          DEF_ARCH_LOG2    = 5;
   localparam int          DEF_PHYS_WIDTH   = 6;
   localparam int          DEF_DRAIN_CYCLES = 2;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h80000180;

endpackage

// File: rtl/recovery_sequencer_rat_copy_walker.sv
// RAT copy walker: steps an index through every architectural register,
// reading the retirement RAT and writing the same entry of the front-end
// RAT in the same cycle. Flags the last entry so the sequencer can leave COPY.
module rat_copy_walker
   import commit_pkg::*;
#(
   parameter int ARCH_LOG2  = DEF_ARCH_LOG2,
   parameter int PHYS_WIDTH = DEF_PHYS_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  FREEZE,
   input  logic                  copyActive,
   input  logic [PHYS_WIDTH-1:0] retRatRdData,
   output logic [ARCH_LOG2-1:0]  retRatRdIdx,
   output logic                  ratWrEn,
   output logic [ARCH_LOG2-1:0]  ratWrIdx,
   output logic [PHYS_WIDTH-1:0] ratWrData,
   output logic                  lastEntry
);

   logic [ARCH_LOG2-1:0] idx;

   // Advance one entry per unfrozen COPY cycle; park at 0 whenever not copying
   // so the next recovery always starts from entry 0
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         idx <= '0;
      end else if (!FREEZE) begin
         if (copyActive) begin
            idx <= idx + ARCH_LOG2'(1);
         end else begin
            idx <= '0;
         end
      end
   end

   assign lastEntry   = copyActive && (idx == {ARCH_LOG2{1'b1}});
   assign retRatRdIdx = copyActive ? idx : '0;
   assign ratWrIdx    = copyActive ? idx : '0;
   assign ratWrData   = copyActive ? retRatRdData : '0;
   assign ratWrEn     = copyActive && !FREEZE;

endmodule

// File: rtl/recovery_sequencer.sv
// Recovery sequencer: on an exception or mispredict at the ROB head it pulses
// the global flush, waits for in-flight writebacks to drain, copies the
// retirement RAT into the front-end RAT, then redirects fetch and rebuilds
// the free list. The front end is stalled for the whole sequence.
// Optional feature macro: RECOVERY_STATS_EN adds saturating counters of
// accepted requests and busy (unfrozen) cycles.
module recovery_sequencer
   import commit_pkg::*;
#(
   parameter int          ARCH_LOG2    = DEF_ARCH_LOG2,
   parameter int          PHYS_WIDTH   = DEF_PHYS_WIDTH,
   parameter int          DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  FREEZE,
   input  logic                  recoverReq_IN,
   input  logic                  recoverIsBranch_IN,
   input  logic [31:0]           recoverPC_IN,
   output logic [ARCH_LOG2-1:0]  retRatRdIdx_OUT,
   input  logic [PHYS_WIDTH-1:0] retRatRdData_IN,
   output logic                  ratWrEn_OUT,
   output logic [ARCH_LOG2-1:0]  ratWrIdx_OUT,
   output logic [PHYS_WIDTH-1:0] ratWrData_OUT,
   output logic                  flushEm_OUT,
   output logic                  stallFront_OUT,
   output logic                  fetchRedirect_OUT,
   output logic [31:0]           fetchPC_OUT,
   output logic                  freelistRebuild_OUT,
   output logic                  busy_OUT
`ifdef RECOVERY_STATS_EN
   ,
   output logic [15:0]           recoverCnt_OUT,
   output logic [31:0]           recoverCyc_OUT
`endif
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   recState_t         state;
   logic [CNT_W-1:0]  drainCnt;
   logic [31:0]       target;
   logic              accept;
   logic              copyActive;
   logic              lastEntry;

   assign accept     = (state == IDLE) && recoverReq_IN && !FREEZE;
   assign copyActive = RESET && (state == COPY);

   // Main recovery FSM with drain counter and redirect target latch; the
   // target is only captured on acceptance so later requests cannot disturb it
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state    <= IDLE;
         drainCnt <= '0;
         target   <= '0;
      end else if (!FREEZE) begin
         case (state)
            IDLE: begin
               if (recoverReq_IN) begin
                  target <= recoverIsBranch_IN ? recoverPC_IN : EXC_VECTOR;
                  state  <= FLUSH;
               end
            end
            FLUSH: begin
               if (DRAIN_CYCLES == 0) begin
                  state <= COPY;
               end else begin
                  drainCnt <= DRAIN_LOAD;
                  state    <= DRAIN;
               end
            end
            DRAIN: begin
               if (drainCnt == '0) begin
                  state <= COPY;
               end else begin
                  drainCnt <= drainCnt - CNT_W'(1);
               end
            end
            COPY: begin
               if (lastEntry) begin
                  state <= REDIRECT;
               end
            end
            REDIRECT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   rat_copy_walker #(
      .ARCH_LOG2  (ARCH_LOG2),
      .PHYS_WIDTH (PHYS_WIDTH)
   ) ratWalker (
      .CLK          (CLK),
      .RESET        (RESET),
      .FREEZE       (FREEZE),
      .copyActive   (copyActive),
      .retRatRdData (retRatRdData_IN),
      .retRatRdIdx  (retRatRdIdx_OUT),
      .ratWrEn      (ratWrEn_OUT),
      .ratWrIdx     (ratWrIdx_OUT),
      .ratWrData    (ratWrData_OUT),
      .lastEntry    (lastEntry)
   );

   assign busy_OUT            = RESET && (state != IDLE);
   assign stallFront_OUT      = busy_OUT;
   assign flushEm_OUT         = RESET && !FREEZE && (state == FLUSH);
   assign fetchRedirect_OUT   = RESET && !FREEZE && (state == REDIRECT);
   assign freelistRebuild_OUT = RESET && !FREEZE && (state == REDIRECT);
   assign fetchPC_OUT         = (RESET && (state == REDIRECT)) ? target : '0;

`ifdef RECOVERY_STATS_EN
   logic [15:0] recCnt;
   logic [31:0] recCyc;

   // Saturating statistics: accepted requests and unfrozen busy cycles
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         recCnt <= '0;
         recCyc <= '0;
      end else begin
         if (accept && (recCnt != 16'hFFFF)) begin
            recCnt <= recCnt + 16'd1;
         end
         if (busy_OUT && !FREEZE && (recCyc != 32'hFFFFFFFF)) begin
            recCyc <= recCyc + 32'd1;
         end
      end
   end

   assign recoverCnt_OUT = recCnt;
   assign recoverCyc_OUT = recCyc;
`else
   logic unusedAccept;
   assign unusedAccept = accept;
`endif

endmodule

// File: tb/tb_recovery_sequencer.sv
// Directed testbench for recovery_sequencer. Instance 0 uses the default
// drain length, instance 1 is built with DRAIN_CYCLES=0. Expected outputs
// come from a cycle-phase schedule and a retirement RAT model in the bench.
module tb_recovery_sequencer;

   logic        CLK;
   logic        RESET;
   logic        FREEZE;
   logic        recoverReq[2];
   logic        recoverIsBranch;
   logic [31:0] recoverPC;
   logic [4:0]  rdIdx[2];
   logic [5:0]  rdData[2];
   logic        wrEn[2];
   logic [4:0]  wrIdx[2];
   logic [5:0]  wrData[2];
   logic        flushEm[2];
   logic        stallFront[2];
   logic        redirect[2];
   logic [31:0] fetchPc[2];
   logic        rebuild[2];
   logic        busy[2];
`ifdef RECOVERY_STATS_EN
   logic [15:0] recCnt[2];
   logic [31:0] recCyc[2];
`endif

   logic [5:0]  retRat[32];
   int          checks = 0;
   int          errors = 0;

   recovery_sequencer dut0 (
      .CLK                 (CLK),
      .RESET               (RESET),
      .FREEZE              (FREEZE),
      .recoverReq_IN       (recoverReq[0]),
      .recoverIsBranch_IN  (recoverIsBranch),
      .recoverPC_IN        (recoverPC),
      .retRatRdIdx_OUT     (rdIdx[0]),
      .retRatRdData_IN     (rdData[0]),
      .ratWrEn_OUT         (wrEn[0]),
      .ratWrIdx_OUT        (wrIdx[0]),
      .ratWrData_OUT       (wrData[0]),
      .flushEm_OUT         (flushEm[0]),
      .stallFront_OUT      (stallFront[0]),
      .fetchRedirect_OUT   (redirect[0]),
      .fetchPC_OUT         (fetchPc[0]),
      .freelistRebuild_OUT (rebuild[0]),
      .busy_OUT            (busy[0])
`ifdef RECOVERY_STATS_EN
      ,
      .recoverCnt_OUT      (recCnt[0]),
      .recoverCyc_OUT      (recCyc[0])
`endif
   );

   recovery_sequencer #(.DRAIN_CYCLES(0)) dut1 (
      .CLK                 (CLK),
      .RESET               (RESET),
      .FREEZE              (FREEZE),
      .recoverReq_IN       (recoverReq[1]),
      .recoverIsBranch_IN  (recoverIsBranch),
      .recoverPC_IN        (recoverPC),
      .retRatRdIdx_OUT     (rdIdx[1]),
      .retRatRdData_IN     (rdData[1]),
      .ratWrEn_OUT         (wrEn[1]),
      .ratWrIdx_OUT        (wrIdx[1]),
      .ratWrData_OUT       (wrData[1]),
      .flushEm_OUT         (flushEm[1]),
      .stallFront_OUT      (stallFront[1]),
      .fetchRedirect_OUT   (redirect[1]),
      .fetchPC_OUT         (fetchPc[1]),
      .freelistRebuild_OUT (rebuild[1]),
      .busy_OUT            (busy[1])
`ifdef RECOVERY_STATS_EN
      ,
      .recoverCnt_OUT      (recCnt[1]),
      .recoverCyc_OUT      (recCyc[1])
`endif
   );

   // Retirement RAT read ports answer in the same cycle
   assign rdData[0] = retRat[rdIdx[0]];
   assign rdData[1] = retRat[rdIdx[1]];

   // Free-running clock, posedge active
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic frz, input logic req0, input logic req1,
                                input logic isBr, input logic [31:0] pc);
      @(posedge CLK);
      #1;
      RESET           = rst;
      FREEZE          = frz;
      recoverReq[0]   = req0;
      recoverReq[1]   = req1;
      recoverIsBranch = isBr;
      recoverPC       = pc;
   endtask

   task automatic seedRetRat(input int seed);
      for (int i = 0; i < 32; i++) begin
         retRat[i] = 6'((i * 5 + seed) & 63);
      end
   endtask

   // Compare every output of one instance against the schedule: phase 0 is
   // idle, 1 flush, then drain, 32 copy phases, redirect, then idle again
   task automatic checkCycle(input int dut, input int p, input logic frz, input int drain,
                             input logic [31:0] expPc, input logic allZero);
      logic        eFlush, eBusy, eWr, eRedir;
      logic [4:0]  eIdx;
      logic [5:0]  eData;
      logic [31:0] ePc;
      int          copyStart, redir;
      string       pre;
      eFlush = 0; eBusy = 0; eWr = 0; eRedir = 0; eIdx = 0; eData = 0; ePc = 0;
      copyStart = 2 + drain;
      redir     = copyStart + 32;
      if (!allZero && p > 0 && p <= redir) begin
         eBusy = 1;
         if (p == 1) eFlush = !frz;
         if (p >= copyStart && p < redir) begin
            eIdx  = 5'(p - copyStart);
            eWr   = !frz;
            eData = retRat[eIdx];
         end
         if (p == redir) begin
            eRedir = !frz;
            ePc    = expPc;
         end
      end
      pre = $sformatf("d%0d p%0d%s", dut, p, allZero ? " rst" : "");
      checkOutput({pre, " flush"},   flushEm[dut],    eFlush);
      checkOutput({pre, " busy"},    busy[dut],       eBusy);
      checkOutput({pre, " stall"},   stallFront[dut], eBusy);
      checkOutput({pre, " wrEn"},    wrEn[dut],       eWr);
      checkOutput({pre, " wrIdx"},   wrIdx[dut],      eIdx);
      checkOutput({pre, " rdIdx"},   rdIdx[dut],      eIdx);
      checkOutput({pre, " wrData"},  wrData[dut],     eData);
      checkOutput({pre, " redir"},   redirect[dut],   eRedir);
      checkOutput({pre, " rebuild"}, rebuild[dut],    eRedir);
      checkOutput({pre, " pc"},      fetchPc[dut],    ePc);
   endtask

   // One full recovery with optional freeze, ignored second request or mid-copy reset
   task automatic runRecovery(input int dut, input logic isBr, input logic [31:0] pc, input int drain,
                              input int expRedir, input int freezeIdx, input int freezeLen,
                              input int secondIdx, input int resetIdx);
      logic [31:0] expPc, drvPc;
      logic        frz, rst, rq, drvBr;
      int          p, frozenCnt, copyStart, redir;
      bit          done;
      expPc     = isBr ? pc : 32'h80000180;
      copyStart = 2 + drain;
      redir     = copyStart + 32;
      applyStimulus(1'b1, 1'b0, dut == 0, dut == 1, isBr, pc);
      @(negedge CLK);
      checkCycle(dut, 0, 1'b0, drain, expPc, 1'b0);
      p = 1; frozenCnt = 0; done = 0;
      for (int n = 1; n <= 120 && !done; n++) begin
         rq = 0; rst = 0; frz = 0; drvPc = pc; drvBr = isBr;
         if (p == 1) rq = 1;
         if (secondIdx >= 0 && p == copyStart + secondIdx) begin
            rq = 1; drvPc = 32'h00500200; drvBr = 1;
         end
         if (freezeIdx >= 0 && p == copyStart + freezeIdx && frozenCnt < freezeLen) frz = 1;
         if (resetIdx >= 0 && p == copyStart + resetIdx) rst = 1;
         applyStimulus(!rst, frz, rq && dut == 0, rq && dut == 1, drvBr, drvPc);
         @(negedge CLK);
         if (rst) begin
            checkCycle(dut, p, 1'b0, drain, expPc, 1'b1);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            @(negedge CLK);
            checkCycle(dut, 0, 1'b0, drain, expPc, 1'b0);
            done = 1;
         end else begin
            checkCycle(dut, p, frz, drain, expPc, 1'b0);
            if (p == redir && !frz) checkOutput("redirCycle", n, expRedir);
            if (frz) begin
               frozenCnt++;
            end else begin
               if (p == redir + 1) done = 1;
               p++;
            end
         end
      end
      if (!done) checkOutput("timeout", 1, 0);
   endtask

   // Directed scenario list
   initial begin
      RESET = 0; FREEZE = 0; recoverReq[0] = 0; recoverReq[1] = 0;
      recoverIsBranch = 0; recoverPC = 0;
      seedRetRat(3);

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00400100);
      @(negedge CLK);
      checkCycle(0, 0, 1'b0, 2, 32'h0, 1'b1);
      checkCycle(1, 0, 1'b0, 0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge CLK);
      checkCycle(0, 0, 1'b0, 2, 32'h0, 1'b1);

      $display("[TB] request held while frozen in IDLE");
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00400100);
         @(negedge CLK);
         checkCycle(0, 0, 1'b1, 2, 32'h0, 1'b0);
      end

      $display("[TB] test 1: mispredict");
      runRecovery(0, 1'b1, 32'h00400100, 2, 36, -1, 0, -1, -1);

      $display("[TB] test 2: exception");
      seedRetRat(17);
      runRecovery(0, 1'b0, 32'h12345678, 2, 36, -1, 0, -1, -1);

      $display("[TB] test 3: freeze during copy");
      seedRetRat(40);
      runRecovery(0, 1'b1, 32'h00400200, 2, 39, 10, 3, -1, -1);

      $display("[TB] test 4: second request during copy");
      runRecovery(0, 1'b1, 32'h00400300, 2, 36, -1, 0, 5, -1);

      $display("[TB] test 5: reset mid-copy then restart");
      runRecovery(0, 1'b1, 32'h00400400, 2, 0, -1, 0, -1, 20);
      seedRetRat(9);
      runRecovery(0, 1'b1, 32'h00400500, 2, 36, -1, 0, -1, -1);

      $display("[TB] test 6: zero drain build");
      runRecovery(1, 1'b1, 32'h00400600, 0, 34, -1, 0, -1, -1);

`ifdef RECOVERY_STATS_EN
      checkOutput("stats cnt0", recCnt[0], 1);
      checkOutput("stats cyc0", recCyc[0], 36);
      checkOutput("stats cnt1", recCnt[1], 1);
      checkOutput("stats cyc1", recCyc[1], 34);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
